// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice: the arbiter FSM
// state type and the default values of the block parameters.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int NREQ_DEFAULT = 4;       // requesters sharing one transmitter
    localparam int DBIT_DEFAULT = 8;       // data bits per frame
    localparam int TMO_DEFAULT  = 65535;   // max cycles waiting for tx_done_tick

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for any requester
        ST_START = 2'd1,   // one-cycle tx_start / req_ready
        ST_WAIT  = 2'd2    // frame in flight, timeout counter running
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake, the UART transmitter handshake and the
// arbiter status flags.
//   master : the arbiter (drives req_ready, tx_start, tx_din, grant_id,
//            busy, timeout_err; samples req_valid, req_data, tx_done_tick)
//   slave  : the environment (requesters + UART transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DBIT = DBIT_DEFAULT
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;     // per-requester byte pending
    logic [NREQ*DBIT-1:0] req_data;      // requester i at [i*DBIT +: DBIT]
    logic [NREQ-1:0]      req_ready;     // one-cycle accept pulse
    logic                 tx_start;      // one-cycle start to the transmitter
    logic [DBIT-1:0]      tx_din;        // byte for the transmitter
    logic                 tx_done_tick;  // end-of-frame pulse from the transmitter
    logic [IDX_W-1:0]     grant_id;      // requester currently or last served
    logic                 busy;          // arbiter not idle
    logic                 timeout_err;   // one-cycle pulse on frame abort

    modport master (
        input  req_valid, req_data, tx_done_tick,
        output req_ready, tx_start, tx_din, grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_done_tick,
        input  req_ready, tx_start, tx_din, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches upward from last_grant+1 with
// wrap-around and returns the first valid requester.
//   valid      : request vector
//   last_grant : index granted most recently
//   any        : at least one request present
//   index      : winning requester (meaningful only when any is high)
// -----------------------------------------------------------------------------
module rr_picker
    import uart_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEFAULT,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic             any,
    output logic [IDX_W-1:0] index
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;   // lowest valid index above last_grant
    logic [IDX_W-1:0] lo_idx;   // lowest valid index at or below last_grant

    // The wrap-around search is split in two halves: anything above
    // last_grant beats anything at or below it. Scanning downward means the
    // final hit in each half is its lowest index, so no modulo is needed.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                if (IDX_W'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end else begin
                    lo_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign any   = |valid;
    assign index = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NREQ requesters using round-robin
// arbitration. IDLE grants a requester and latches its byte, START issues a
// one-cycle tx_start together with the requester's req_ready, and WAIT holds
// until tx_done_tick or until TMO cycles pass, in which case the frame is
// abandoned with a timeout_err pulse.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_tx_arbiter_if.master (requester, transmitter, status)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DBIT = DBIT_DEFAULT,
    parameter int TMO  = TMO_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    uart_tx_arbiter_if.master    bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TMO + 1);

    // The counter reads k-1 during the k-th WAIT cycle, so the abort edge is
    // the one ending WAIT cycle TMO.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);
    // Makes requester 0 the first winner after reset.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_id;
    logic [DBIT-1:0]  tx_din;
    logic [NREQ-1:0]  req_ready;
    logic             timeout_err;
    logic [CNT_W-1:0] tmo_cnt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [NREQ-1:0]  pick_onehot;
    logic [DBIT-1:0]  pick_data;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .index      (pick_idx)
    );

    // Decode the winner into its ready bit and its byte lane. Slice offsets
    // are elaboration constants, so this is a plain mux.
    always_comb begin
        pick_onehot = '0;
        pick_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_onehot[i] = 1'b1;
                pick_data      = bus.req_data[i*DBIT +: DBIT];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_LAST;
            grant_id    <= '0;
            tx_din      <= '0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Pulses default low and are raised only on the edge that earns them.
            req_ready   <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        tx_din     <= pick_data;
                        req_ready  <= pick_onehot;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    // tx_done_tick here belongs to no frame of ours; ignore it.
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a simultaneous timeout.
                    if (bus.tx_done_tick) begin
                        state <= ST_IDLE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.tx_start    = (state == ST_START);
    assign bus.tx_din      = tx_din;
    assign bus.grant_id    = grant_id;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Requesters are modelled as per-index byte FIFOs. Each batch of bytes is
// loaded while the arbiter is idle; the expected grant sequence is derived
// from the round-robin rule and pushed to a scoreboard that a monitor drains
// on every tx_start. A UART responder answers each tx_start after a chosen
// delay and records when it pulsed tx_done_tick.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DBIT  = 8;
    localparam int TMO   = 20;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
        logic       b2b;    // follows the previous grant without a gap
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t       exp_q[$];
    logic [7:0] req_mem [NREQ][DEPTH];
    int         head [NREQ];
    int         tail [NREQ];
    logic [NREQ-1:0] withdraw_mask = '0;

    int  resp_mode     = 1;     // 0 random delay+stray, 1 fixed delay, 2 silent
    int  resp_delay    = 10;
    bit  stray_en      = 1'b0;
    int  last_done_cyc = 0;
    bit  expect_timeout = 1'b0;

    int         model_last    = NREQ - 1;
    bit         model_granted = 1'b0;
    logic [7:0] model_last_data = '0;
    int         batch_cnt [NREQ];
    bit         batch_fixed = 1'b0;
    logic [7:0] fixed_data [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Requesters: present the head byte while anything is queued, pop on ready.
    initial begin : driver
        bus.req_valid = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i] && head[i] != tail[i]) head[i]++;
                bus.req_valid[i] = (head[i] != tail[i]) || withdraw_mask[i];
                bus.req_data[i*DBIT +: DBIT] = (head[i] != tail[i]) ? req_mem[i][head[i] % DEPTH] : 8'hEE;
            end
        end
    end

    // UART transmitter model.
    initial begin : responder
        int d;
        bit stray;
        bus.tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done_tick = 1'b0;
            if (bus.tx_start) begin
                d     = (resp_mode == 0) ? int'($urandom_range(1, 15)) : resp_delay;
                stray = (resp_mode == 0) && ($urandom_range(0, 3) == 0);
                if (resp_mode != 2) begin
                    if (stray) bus.tx_done_tick = 1'b1;   // lands in START
                    @(negedge clk);
                    bus.tx_done_tick = 1'b0;
                    repeat (d - 1) @(negedge clk);
                    bus.tx_done_tick = 1'b1;
                    last_done_cyc    = cyc;
                    @(negedge clk);
                    bus.tx_done_tick = 1'b0;
                end
            end else if (stray_en && !bus.busy) begin
                bus.tx_done_tick = 1'b1;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!expect_timeout) check("timeout_err_quiet", bus.timeout_err, 0);
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_id", bus.grant_id, e.id);
                    check("tx_din", bus.tx_din, e.data);
                    check("req_ready", bus.req_ready, onehot(int'(e.id)));
                    check("busy_in_start", bus.busy, 1);
                    if (e.b2b) check("grant_spacing", cyc - last_done_cyc, 2);
                end
            end else begin
                check("req_ready_quiet", bus.req_ready, 0);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Load a batch of bytes and derive the grant order from the round-robin
    // rule: starting after the last winner, the first non-empty FIFO wins.
    task automatic load_batch();
        int         pend [NREQ];
        int         rd   [NREQ];
        logic [7:0] bytes [NREQ][4];
        int         total;
        int         j;
        bit         first;
        logic [7:0] b;
        exp_t       e;
        @(posedge clk);
        #1;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = batch_cnt[i];
            rd[i]   = 0;
            total  += batch_cnt[i];
            for (int k = 0; k < batch_cnt[i]; k++) begin
                b = batch_fixed ? fixed_data[i] : 8'($urandom_range(0, 255));
                bytes[i][k] = b;
                req_mem[i][tail[i] % DEPTH] = b;
                tail[i]++;
            end
        end
        first = 1'b1;
        while (total > 0) begin
            j = -1;
            for (int k = 1; k <= NREQ; k++)
                if (j < 0 && pend[(model_last + k) % NREQ] > 0) j = (model_last + k) % NREQ;
            e.id   = 8'(j);
            e.data = bytes[j][rd[j]];
            e.b2b  = !first;
            exp_q.push_back(e);
            rd[j]++;
            pend[j]--;
            total--;
            model_last      = j;
            model_last_data = e.data;
            model_granted   = 1'b1;
            first           = 1'b0;
        end
    endtask

    task automatic set_batch(input int c0, input int c1, input int c2, input int c3);
        batch_cnt[0] = c0;
        batch_cnt[1] = c1;
        batch_cnt[2] = c2;
        batch_cnt[3] = c3;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_budget", (n < budget), 1);
        if (model_granted) begin
            check("tx_din_hold", bus.tx_din, model_last_data);
            check("grant_id_hold", bus.grant_id, model_last);
        end
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!bus.tx_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_start_within_budget", bus.tx_start, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_tx_start"}, bus.tx_start, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
        check({tag, "_grant_id"}, bus.grant_id, 0);
        check({tag, "_tx_din"}, bus.tx_din, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset         = 1'b0;
        model_last    = NREQ - 1;
        model_granted = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        int seen;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // First grant after reset goes to requester 0 with its byte.
        resp_mode     = 1;
        resp_delay    = 10;
        batch_fixed   = 1'b1;
        fixed_data[0] = 8'hA5;
        set_batch(1, 0, 0, 0);
        load_batch();
        wait_idle(200);
        batch_fixed = 1'b0;

        // All four held from reset: order 0,1,2,3,0.
        do_reset();
        set_batch(2, 1, 1, 1);
        load_batch();
        wait_idle(400);

        // Grant to 3, then requester 2 alone wraps and is re-granted back to back.
        set_batch(0, 0, 0, 1);
        load_batch();
        wait_idle(200);
        resp_delay = 1;
        set_batch(0, 0, 3, 0);
        load_batch();
        wait_idle(200);

        // tx_done_tick while idle changes nothing.
        stray_en = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.busy) seen++;
        end
        stray_en = 1'b0;
        check("busy_on_stray_done", seen, 0);

        // Done exactly on the last allowed WAIT cycle beats the timeout.
        resp_delay = TMO;
        set_batch(0, 1, 0, 0);
        load_batch();
        wait_idle(200);

        // No done at all: timeout 20 cycles after entering WAIT. A request
        // raised and dropped during WAIT must leave no trace.
        resp_mode = 2;
        set_batch(0, 0, 0, 1);
        load_batch();
        wait_start(50);
        expect_timeout = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (n == 5) withdraw_mask = 4'b0010;
            if (n == 8) withdraw_mask = 4'b0000;
            if (bus.timeout_err) break;
        end
        check("timeout_latency", n, TMO + 1);
        check("busy_after_timeout", bus.busy, 0);
        @(negedge clk);
        check("timeout_single_pulse", bus.timeout_err, 0);
        expect_timeout = 1'b0;
        wait_idle(100);

        // Reset in the middle of WAIT clears everything at once.
        resp_mode  = 1;
        resp_delay = TMO;
        set_batch(0, 1, 0, 0);
        load_batch();
        wait_start(50);
        repeat (3) @(negedge clk);
        check("busy_before_reset", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset         = 1'b0;
        model_last    = NREQ - 1;
        model_granted = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx_start || bus.req_ready != 0) seen++;
        end
        check("quiet_after_reset", seen, 0);

        // Randomized batches with random latency and stray ticks in START.
        resp_mode = 0;
        for (int b = 0; b < 40; b++) begin
            set_batch($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            load_batch();
            wait_idle(600);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one UART transmitter (range 2..8).
REQ-002 The block SHALL have parameter DBIT, default 8, giving the data bits per frame.
REQ-003 The block SHALL have parameter TMO, default 65535, giving the maximum cycles to wait for tx_done_tick before abort.
REQ-004 clk  input  1  system clock, all state on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester byte-pending flag; bit i belongs to requester i.
REQ-007 req_data  input  NREQ*DBIT  packed bytes; requester i occupies bits [i*DBIT +: DBIT].
REQ-008 req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_din  output  DBIT  byte for the transmitter, held stable from tx_start until the next grant.
REQ-011 tx_done_tick  input  1  one-cycle end-of-frame pulse from the transmitter.
REQ-012 grant_id  output  $clog2(NREQ)  index of the requester currently or last served.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, START and WAIT.
REQ-016 IDLE: at an edge with any req_valid high, the FSM SHALL select requester g, load tx_din<=req_data[g] and grant_id<=g, set req_ready[g] for the next cycle only, and go to START.
REQ-017 IDLE with no req_valid high SHALL hold all state, with req_ready, tx_start and timeout_err low.
REQ-018 Selection SHALL be round-robin: search from (last_grant+1) mod NREQ upward with wrap-around; the first valid requester wins.
REQ-019 last_grant SHALL update to g at each grant.
REQ-020 START SHALL drive tx_start=1 for exactly one cycle (Moore output), clear the timeout counter, and go to WAIT at the next edge.
REQ-021 WAIT: tx_done_tick=1 SHALL return the FSM to IDLE at that edge, so the next grant can occur one cycle later.
REQ-022 WAIT: the timeout counter SHALL increment each cycle; on reaching TMO without tx_done_tick, the FSM SHALL pulse timeout_err for one cycle and return to IDLE.
REQ-023 If tx_done_tick and the timeout occur in the same cycle, tx_done_tick SHALL win and timeout_err SHALL stay low.
REQ-024 tx_done_tick in IDLE or START SHALL be ignored.
REQ-025 req_valid SHALL be sampled only in IDLE; a requester holds req_valid and req_data until its req_ready pulse, and may present a new byte from the following cycle.
REQ-026 Minimum spacing between grants SHALL be 3 cycles (IDLE, START, one WAIT cycle); with a single persistent requester the same index SHALL be re-granted.
REQ-027 req_valid dropping before grant SHALL withdraw the request with no side effect.

Reset
REQ-028 Reset SHALL force state=IDLE, last_grant=NREQ-1 (requester 0 has first priority), grant_id=0, tx_din=0, and the timeout counter=0.
REQ-029 Reset SHALL force req_ready=0, tx_start=0, busy=0 and timeout_err=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately, with no tx_start or req_ready emitted after release until a new grant.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum (arb_state_t) and the default parameter constants.
REQ-032 Round-robin selection SHALL live in the combinational sub-module rr_picker (inputs valid vector and last_grant; outputs any and index).
REQ-033 The timeout counter width SHALL be $clog2(TMO+1); there SHALL be no other arithmetic.

Verification
REQ-034 Reset release, req_valid=4'b0001, data0=8'hA5 -> req_ready=4'b0001 one cycle after the edge, tx_start in the same cycle, tx_din=8'hA5, grant_id=0.
REQ-035 All four valid and held, tx_done_tick 10 cycles after each tx_start -> grant order 0,1,2,3,0, and each req_ready is a single cycle.
REQ-036 Only requester 2 valid after a grant to 3 -> wrap search selects 2; then requester 2 alone, repeatedly -> 2,2,2 with 3-cycle minimum spacing.
REQ-037 TMO=20, no tx_done_tick -> timeout_err pulses exactly 20 cycles after entering WAIT and busy falls; a case with tx_done_tick at cycle 20 -> no timeout_err.
REQ-038 Reset asserted during WAIT -> all outputs 0 immediately; after release, with req_valid=0, no tx_start for 50 cycles.
REQ-039 tx_done_tick injected in IDLE and START -> no state change and no extra tx_start.
